// File: rtl/maze_walker_pkg.sv
// -----------------------------------------------------------------------------
// maze_pkg: shared types and helpers for the maze_walker block.
//   state_t    : walker FSM states.
//   dir_t      : compass heading, 2-bit, clockwise order N, E, S, W.
//   turn_right : heading after a 90 degree clockwise turn.
//   turn_left  : heading after a 90 degree counter-clockwise turn.
//   turn_back  : heading after a 180 degree turn.
// -----------------------------------------------------------------------------
package maze_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FIND_EXIT,
        FIND_ENTRY,
        WALK,
        DONE,
        FAIL
    } state_t;

    typedef enum logic [1:0] {
        NORTH,
        EAST,
        SOUTH,
        WEST
    } dir_t;

    function automatic dir_t turn_right(input dir_t d);
        case (d)
            NORTH:   return EAST;
            EAST:    return SOUTH;
            SOUTH:   return WEST;
            default: return NORTH;
        endcase
    endfunction

    function automatic dir_t turn_left(input dir_t d);
        case (d)
            NORTH:   return WEST;
            WEST:    return SOUTH;
            SOUTH:   return EAST;
            default: return NORTH;
        endcase
    endfunction

    function automatic dir_t turn_back(input dir_t d);
        case (d)
            NORTH:   return SOUTH;
            SOUTH:   return NORTH;
            EAST:    return WEST;
            default: return EAST;
        endcase
    endfunction

endpackage

// File: rtl/maze_walker_if.sv
// -----------------------------------------------------------------------------
// maze_walker_if: request/result bundle between the maze source, the walker
// and the display/scoring logic.
//   maze      : SIZE x SIZE bitmap, maze[y][x], 1 = wall (master -> walker)
//   start     : single-cycle run request                (master -> walker)
//   left_hand : 0 = right-hand rule, 1 = left-hand rule (master -> walker)
//   x, y      : current position                        (walker -> master)
//   steps     : moves taken                             (walker -> master)
//   busy      : run in progress                         (walker -> master)
//   done      : exit reached, sticky                    (walker -> master)
//   fail      : run aborted, sticky                     (walker -> master)
//   path      : visited-cell bitmap, path[y][x]         (walker -> master)
// -----------------------------------------------------------------------------
interface maze_walker_if #(
    parameter int SIZE      = 9,
    parameter int MAX_STEPS = 255
);
    localparam int N = $clog2(SIZE);
    localparam int S = $clog2(MAX_STEPS + 1);

    logic [SIZE-1:0][SIZE-1:0] maze;
    logic                      start;
    logic                      left_hand;
    logic [N-1:0]              x;
    logic [N-1:0]              y;
    logic [S-1:0]              steps;
    logic                      busy;
    logic                      done;
    logic                      fail;
    logic [SIZE-1:0][SIZE-1:0] path;

    modport master (
        output maze, start, left_hand,
        input  x, y, steps, busy, done, fail, path
    );

    modport slave (
        input  maze, start, left_hand,
        output x, y, steps, busy, done, fail, path
    );

endinterface

// File: rtl/maze_walker_nbr_sel.sv
// -----------------------------------------------------------------------------
// maze_nbr_sel: combinational neighbour selector for the wall follower.
// Probes the four neighbours of (x_i, y_i) in wall-follower preference order
// relative to heading_i and returns the first open one.
//   maze_i         : maze bitmap, maze_i[y][x], 1 = wall
//   x_i, y_i       : current cell
//   heading_i      : current heading
//   left_hand_i    : 0 = right, straight, left, back; 1 = left, straight, right, back
//   next_x_o/_y_o  : chosen cell (equals current cell when blocked)
//   next_heading_o : heading after the move
//   blocked_o      : all four neighbours are walls or off-grid
// -----------------------------------------------------------------------------
module maze_nbr_sel
    import maze_pkg::*;
#(
    parameter  int SIZE = 9,
    localparam int N    = $clog2(SIZE)
) (
    input  logic [SIZE-1:0][SIZE-1:0] maze_i,
    input  logic [N-1:0]              x_i,
    input  logic [N-1:0]              y_i,
    input  dir_t                      heading_i,
    input  logic                      left_hand_i,
    output logic [N-1:0]              next_x_o,
    output logic [N-1:0]              next_y_o,
    output dir_t                      next_heading_o,
    output logic                      blocked_o
);

    localparam logic [N-1:0] EDGE = N'(SIZE - 1);

    dir_t cand [4];

    // Off-grid neighbours count as walls; the bitmap is only indexed once the
    // candidate coordinate is known to lie inside 0..SIZE-1.
    function automatic logic probe(input logic [SIZE-1:0][SIZE-1:0] m,
                                   input logic [N-1:0] px,
                                   input logic [N-1:0] py,
                                   input dir_t d,
                                   output logic [N-1:0] cx,
                                   output logic [N-1:0] cy);
        logic open;
        cx   = px;
        cy   = py;
        open = 1'b0;
        case (d)
            NORTH: if (py != '0)   begin cy = py - 1'b1; open = !m[cy][cx]; end
            EAST:  if (px != EDGE) begin cx = px + 1'b1; open = !m[cy][cx]; end
            SOUTH: if (py != EDGE) begin cy = py + 1'b1; open = !m[cy][cx]; end
            default: if (px != '0) begin cx = px - 1'b1; open = !m[cy][cx]; end
        endcase
        return open;
    endfunction

    always_comb begin
        if (left_hand_i) begin
            cand[0] = turn_left(heading_i);
            cand[2] = turn_right(heading_i);
        end else begin
            cand[0] = turn_right(heading_i);
            cand[2] = turn_left(heading_i);
        end
        cand[1] = heading_i;
        cand[3] = turn_back(heading_i);
    end

    always_comb begin
        logic [N-1:0] cx;
        logic [N-1:0] cy;
        logic         open;
        logic         found;
        next_x_o       = x_i;
        next_y_o       = y_i;
        next_heading_o = heading_i;
        found          = 1'b0;
        for (int i = 0; i < 4; i++) begin
            open = probe(maze_i, x_i, y_i, cand[i], cx, cy);
            if (open && !found) begin
                found          = 1'b1;
                next_x_o       = cx;
                next_y_o       = cy;
                next_heading_o = cand[i];
            end
        end
        blocked_o = !found;
    end

endmodule

// File: rtl/maze_walker.sv
// -----------------------------------------------------------------------------
// maze_walker: parametrised wall-follower maze solver.
// On start it scans the bottom row for the exit column, scans the top row for
// the entry column, then walks with the right- or left-hand rule until it
// stands on the exit (done) or runs out of moves / gets boxed in (fail).
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   bus  : maze_walker_if.slave (maze, start, left_hand in;
//          x, y, steps, busy, done, fail, path out)
// Build option: define MAZE_WALKER_PATH_EN to build the visited-cell bitmap;
// without it path is tied to all zeros.
// -----------------------------------------------------------------------------
module maze_walker
    import maze_pkg::*;
#(
    parameter int SIZE      = 9,
    parameter int MAX_STEPS = 255
) (
    input  logic          clk,
    input  logic          rst,
    maze_walker_if.slave  bus
);

    localparam int N = $clog2(SIZE);
    localparam int S = $clog2(MAX_STEPS + 1);

    localparam logic [N-1:0] EDGE     = N'(SIZE - 1);
    localparam logic [N-1:0] TOP_ROW  = '0;
    localparam logic [S-1:0] STEP_MAX = S'(MAX_STEPS);

    state_t       state_q, state_d;
    logic [N-1:0] x_q, x_d;
    logic [N-1:0] y_q, y_d;
    logic [N-1:0] sx_q, sx_d;
    dir_t         heading_q, heading_d;
    logic [S-1:0] steps_q, steps_d;
    logic         lh_q, lh_d;

    logic [N-1:0] nbr_x, nbr_y;
    dir_t         nbr_heading;
    logic         nbr_blocked;

    logic accept, at_exit, exit_open, entry_hit, do_move;

    function automatic logic [S-1:0] sat_inc(input logic [S-1:0] v);
        return (v == STEP_MAX) ? v : v + 1'b1;
    endfunction

    maze_nbr_sel #(.SIZE(SIZE)) u_nbr_sel (
        .maze_i         (bus.maze),
        .x_i            (x_q),
        .y_i            (y_q),
        .heading_i      (heading_q),
        .left_hand_i    (lh_q),
        .next_x_o       (nbr_x),
        .next_y_o       (nbr_y),
        .next_heading_o (nbr_heading),
        .blocked_o      (nbr_blocked)
    );

    // The exit row is fixed to the bottom edge; only the column is searched.
    assign at_exit   = (x_q == sx_q) && (y_q == EDGE);
    assign accept    = (state_q inside {IDLE, DONE, FAIL}) && bus.start;
    assign exit_open = !bus.maze[EDGE][sx_q];
    assign entry_hit = (state_q == FIND_ENTRY) && !bus.maze[TOP_ROW][x_q];
    assign do_move   = (state_q == WALK) && !at_exit
                       && (steps_q != STEP_MAX) && !nbr_blocked;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, FAIL: if (accept) state_d = FIND_EXIT;
            FIND_EXIT: begin
                if (exit_open)          state_d = FIND_ENTRY;
                else if (sx_q == EDGE)  state_d = FAIL;
            end
            FIND_ENTRY: begin
                if (entry_hit)          state_d = WALK;
                else if (x_q == EDGE)   state_d = FAIL;
            end
            WALK: begin
                if (at_exit)                    state_d = DONE;
                else if (steps_q == STEP_MAX)   state_d = FAIL;
                else if (nbr_blocked)           state_d = FAIL;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        sx_d      = sx_q;
        heading_d = heading_q;
        steps_d   = steps_q;
        lh_d      = lh_q;
        if (accept) begin
            x_d     = '0;
            y_d     = '0;
            sx_d    = '0;
            steps_d = '0;
            lh_d    = bus.left_hand;
        end
        if ((state_q == FIND_EXIT) && !exit_open && (sx_q != EDGE))
            sx_d = sx_q + 1'b1;
        if ((state_q == FIND_ENTRY) && !entry_hit && (x_q != EDGE))
            x_d = x_q + 1'b1;
        if (entry_hit)
            heading_d = SOUTH;
        if (do_move) begin
            x_d       = nbr_x;
            y_d       = nbr_y;
            heading_d = nbr_heading;
            steps_d   = sat_inc(steps_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            sx_q      <= '0;
            heading_q <= SOUTH;
            steps_q   <= '0;
            lh_q      <= 1'b0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            sx_q      <= sx_d;
            heading_q <= heading_d;
            steps_q   <= steps_d;
            lh_q      <= lh_d;
        end
    end

    always_comb begin
        bus.x     = x_q;
        bus.y     = y_q;
        bus.steps = steps_q;
        bus.busy  = state_q inside {FIND_EXIT, FIND_ENTRY, WALK};
        bus.done  = (state_q == DONE);
        bus.fail  = (state_q == FAIL);
    end

`ifdef MAZE_WALKER_PATH_EN
    logic [SIZE-1:0][SIZE-1:0] path_q, path_d;

    always_comb begin
        path_d = path_q;
        if (accept)
            path_d = '0;
        else if (entry_hit)
            path_d[TOP_ROW][x_q] = 1'b1;
        else if (do_move)
            path_d[nbr_y][nbr_x] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) path_q <= '0;
        else     path_q <= path_d;
    end

    assign bus.path = path_q;
`else
    assign bus.path = '0;
`endif

endmodule

// File: tb/tb_maze_walker.sv
// -----------------------------------------------------------------------------
// tb_maze_walker: self-checking bench for maze_walker.
// dut_a: SIZE 5, MAX_STEPS 255.  dut_b: SIZE 5, MAX_STEPS 3.
// Path expectations follow MAZE_WALKER_PATH_EN (all zero when undefined).
// -----------------------------------------------------------------------------
module tb_maze_walker;

    typedef logic [4:0][4:0] grid_t;

    typedef struct {
        bit         done;
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] steps;
        grid_t      path;
        int         lat;
    } exp_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    grid_t maze_v  = '1;
    logic  lh_v    = 1'b0;
    logic  start_a = 1'b0;
    logic  start_b = 1'b0;
    bit    sel_b   = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    exp_t sb[$];

    always #5 clk = ~clk;

    maze_walker_if #(.SIZE(5), .MAX_STEPS(255)) ifa ();
    maze_walker_if #(.SIZE(5), .MAX_STEPS(3))   ifb ();

    assign ifa.maze      = maze_v;
    assign ifa.left_hand = lh_v;
    assign ifa.start     = start_a;
    assign ifb.maze      = maze_v;
    assign ifb.left_hand = lh_v;
    assign ifb.start     = start_b;

    maze_walker #(.SIZE(5), .MAX_STEPS(255)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    maze_walker #(.SIZE(5), .MAX_STEPS(3))   dut_b (.clk(clk), .rst(rst), .bus(ifb));

    logic       o_done, o_fail, o_busy;
    logic [2:0] o_x, o_y;
    logic [7:0] o_steps;
    grid_t      o_path;

    always_comb begin
        if (sel_b) begin
            o_done = ifb.done; o_fail = ifb.fail; o_busy = ifb.busy;
            o_x = ifb.x; o_y = ifb.y; o_steps = {6'b0, ifb.steps}; o_path = ifb.path;
        end else begin
            o_done = ifa.done; o_fail = ifa.fail; o_busy = ifa.busy;
            o_x = ifa.x; o_y = ifa.y; o_steps = ifa.steps; o_path = ifa.path;
        end
    end

    // Mazes, rows listed bottom (row 4) to top (row 0); 1 = wall.
    localparam grid_t CORR   = {5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11011};
    localparam grid_t COL0   = {5'b11110, 5'b11110, 5'b11110, 5'b11110, 5'b11110};
    localparam grid_t COL4   = {5'b01111, 5'b01111, 5'b01111, 5'b01111, 5'b01111};
    localparam grid_t FORK   = {5'b10111, 5'b10101, 5'b10101, 5'b10001, 5'b11011};
    localparam grid_t NOEXIT = {5'b11111, 5'b10101, 5'b10101, 5'b10001, 5'b11011};
    localparam grid_t NOENT  = {5'b11110, 5'b11111, 5'b11111, 5'b11111, 5'b11111};
    localparam grid_t BOXED  = {5'b11011, 5'b11111, 5'b11111, 5'b11111, 5'b11011};

    localparam grid_t P_CORR = {5'b00100, 5'b00100, 5'b00100, 5'b00100, 5'b00100};
    localparam grid_t P_COL0 = {5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
    localparam grid_t P_COL4 = {5'b10000, 5'b10000, 5'b10000, 5'b10000, 5'b10000};
    localparam grid_t P_FRH  = {5'b01000, 5'b01010, 5'b01010, 5'b01110, 5'b00100};
    localparam grid_t P_FLH  = {5'b01000, 5'b01000, 5'b01000, 5'b01100, 5'b00100};
    localparam grid_t P_BOX  = {5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00100};
    localparam grid_t P_LIM  = {5'b00000, 5'b00100, 5'b00100, 5'b00100, 5'b00100};

    function automatic grid_t pexp(input grid_t p);
`ifdef MAZE_WALKER_PATH_EN
        return p;
`else
        return '0;
`endif
    endfunction

    task automatic test_reset();
        @(negedge clk);
        n_vec++; if (ifa.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy_a: got %b want 0", ifa.busy); end
        n_vec++; if (ifa.done !== 1'b0) begin n_err++; $display("FAIL reset_done_a: got %b want 0", ifa.done); end
        n_vec++; if (ifa.fail !== 1'b0) begin n_err++; $display("FAIL reset_fail_a: got %b want 0", ifa.fail); end
        n_vec++; if (ifa.x !== 3'd0 || ifa.y !== 3'd0) begin n_err++; $display("FAIL reset_pos_a: got (%0d,%0d) want (0,0)", ifa.x, ifa.y); end
        n_vec++; if (ifa.steps !== 8'd0) begin n_err++; $display("FAIL reset_steps_a: got %0d want 0", ifa.steps); end
        n_vec++; if (ifa.path !== 25'd0) begin n_err++; $display("FAIL reset_path_a: got %h want 0", ifa.path); end
        n_vec++; if (ifb.busy !== 1'b0 || ifb.done !== 1'b0 || ifb.fail !== 1'b0) begin
            n_err++; $display("FAIL reset_flags_b: got %b%b%b want 000", ifb.busy, ifb.done, ifb.fail);
        end
        rst = 1'b0;
    endtask

    // Drives one run, pushes its expectation, then pops and compares when the
    // walker reports done or fail. poke > 0 re-pulses start that many cycles in.
    task automatic run(input string name, input bit use_b, input grid_t m, input bit lh,
                       input bit e_done, input int ex, input int ey, input int es,
                       input grid_t ep, input int elat, input int poke);
        exp_t e, g;
        int   lat;
        bit   got;
        e.done = e_done; e.x = 3'(ex); e.y = 3'(ey); e.steps = 8'(es);
        e.path = pexp(ep); e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        sel_b = use_b; maze_v = m; lh_v = lh;
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; start_b = 1'b0;
        n_vec++; if (o_busy !== 1'b1) begin n_err++; $display("FAIL %s busy_after_accept: got %b want 1", name, o_busy); end
        lat = 0; got = 1'b0;
        while (!got && lat < 300) begin
            @(negedge clk);
            lat++;
            if (poke > 0 && lat == poke) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            got = o_done | o_fail;
        end
        start_a = 1'b0; start_b = 1'b0;
        g = sb.pop_front();
        n_vec++;
        if (!got) begin
            n_err++; $display("FAIL %s timeout: no done/fail within %0d cycles, want %0d", name, lat, g.lat);
            return;
        end
        n_vec++; if (o_done !== g.done) begin n_err++; $display("FAIL %s done: got %b want %b", name, o_done, g.done); end
        n_vec++; if (o_fail !== !g.done) begin n_err++; $display("FAIL %s fail: got %b want %b", name, o_fail, !g.done); end
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL %s busy_end: got %b want 0", name, o_busy); end
        n_vec++; if (o_x !== g.x || o_y !== g.y) begin n_err++; $display("FAIL %s pos: got (%0d,%0d) want (%0d,%0d)", name, o_x, o_y, g.x, g.y); end
        n_vec++; if (o_steps !== g.steps) begin n_err++; $display("FAIL %s steps: got %0d want %0d", name, o_steps, g.steps); end
        n_vec++; if (o_path !== g.path) begin n_err++; $display("FAIL %s path: got %h want %h", name, o_path, g.path); end
        n_vec++; if (lat != g.lat) begin n_err++; $display("FAIL %s latency: got %0d want %0d", name, lat, g.lat); end
        @(negedge clk);
        n_vec++;
        if (o_done !== g.done || o_fail !== !g.done || o_steps !== g.steps || o_x !== g.x || o_y !== g.y) begin
            n_err++; $display("FAIL %s hold: got d%b f%b s%0d (%0d,%0d) want d%b s%0d (%0d,%0d)",
                              name, o_done, o_fail, o_steps, o_x, o_y, g.done, g.steps, g.x, g.y);
        end
    endtask

    task automatic test_walks();
        run("corridor_rh", 1'b0, CORR, 1'b0, 1'b1, 2, 4, 4,  P_CORR, 11, 0);
        run("col0_rh",     1'b0, COL0, 1'b0, 1'b1, 0, 4, 4,  P_COL0, 7,  0);
        run("col4_lh",     1'b0, COL4, 1'b1, 1'b1, 4, 4, 4,  P_COL4, 15, 0);
        run("fork_rh",     1'b0, FORK, 1'b0, 1'b1, 3, 4, 11, P_FRH,  19, 0);
        run("fork_lh",     1'b0, FORK, 1'b1, 1'b1, 3, 4, 5,  P_FLH,  13, 0);
    endtask

    task automatic test_failures();
        run("no_exit",  1'b0, NOEXIT, 1'b0, 1'b0, 0, 0, 0, '0,    5, 0);
        run("no_entry", 1'b0, NOENT,  1'b0, 1'b0, 4, 0, 0, '0,    6, 0);
        run("boxed",    1'b0, BOXED,  1'b0, 1'b0, 2, 0, 0, P_BOX, 7, 0);
    endtask

    task automatic test_step_limit();
        run("limit_1", 1'b1, CORR, 1'b0, 1'b0, 2, 3, 3, P_LIM, 10, 0);
        run("limit_2", 1'b1, CORR, 1'b0, 1'b0, 2, 3, 3, P_LIM, 10, 0);
    endtask

    task automatic test_mid_reset();
        int n;
        @(negedge clk);
        sel_b = 1'b0; maze_v = FORK; lh_v = 1'b0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        n = 0;
        while (o_steps != 8'd6 && n < 100) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (o_steps != 8'd6) begin
            n_err++; $display("FAIL mid_reset_reach: got steps %0d want 6", o_steps);
        end
        rst = 1'b1;
        #1;
        n_vec++; if (o_busy !== 1'b0 || o_done !== 1'b0 || o_fail !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_flags: got b%b d%b f%b want 000", o_busy, o_done, o_fail);
        end
        n_vec++; if (o_x !== 3'd0 || o_y !== 3'd0) begin n_err++; $display("FAIL mid_reset_pos: got (%0d,%0d) want (0,0)", o_x, o_y); end
        n_vec++; if (o_steps !== 8'd0) begin n_err++; $display("FAIL mid_reset_steps: got %0d want 0", o_steps); end
        n_vec++; if (o_path !== 25'd0) begin n_err++; $display("FAIL mid_reset_path: got %h want 0", o_path); end
        @(negedge clk);
        rst = 1'b0;
        n_vec++; if (o_busy !== 1'b0 || o_steps !== 8'd0) begin
            n_err++; $display("FAIL mid_reset_idle: got b%b s%0d want b0 s0", o_busy, o_steps);
        end
    endtask

    task automatic test_back_to_back();
        run("busy_start_ignored", 1'b0, FORK, 1'b1, 1'b1, 3, 4, 5, P_FLH, 13, 3);
        run("restart_from_done",  1'b0, CORR, 1'b0, 1'b1, 2, 4, 4, P_CORR, 11, 0);
    endtask

    initial begin
        test_reset();
        test_walks();
        test_failures();
        test_step_limit();
        test_mid_reset();
        test_back_to_back();
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/maze_walker.md
Name: maze_walker

Overview:
- Parametrised wall-follower maze solver; successor to the fixed 9x9 right-hand escaper.
- Generalises grid size, adds selectable left/right-hand rule, start/busy/done/fail handshake, step limit and bounds-safe neighbour checks.
- Sits between the maze source (bitmap, 1 = wall) and the display/scoring logic. Outputs the current position, the move count and the visited-cell bitmap.

Parameters:
- SIZE, 9, maze edge length in cells; legal range 2 or more.
- MAX_STEPS, 255, move budget before the walk is aborted with fail.
- N, $clog2(SIZE), coordinate width; localparam, not overridable.
- S, $clog2(MAX_STEPS+1), step counter width; localparam.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- maze, in, SIZE x SIZE, row y is bit vector maze[y], bit x is cell (x,y); 1 = wall; must be held stable while busy.
- start, in, 1, single-cycle request; accepted only in IDLE, DONE or FAIL.
- left_hand, in, 1, sampled at start; 0 = right-hand rule, 1 = left-hand rule.
- x, out, N, current column.
- y, out, N, current row.
- steps, out, S, moves taken.
- busy, out, 1, high from the accept cycle+1 until done or fail.
- done, out, 1, exit reached; sticky until the next start or rst.
- fail, out, 1, no entry, no exit, boxed-in cell or budget exhausted; sticky.
- path, out, SIZE x SIZE, visited-cell bitmap, same indexing as maze.

Behaviour:
- Reset state: state = IDLE; x = y = 0; steps = 0; busy = done = fail = 0; path all 0; exit registers sx = 0, sy = SIZE-1; heading = SOUTH.
- Reset mid-operation aborts immediately to these values.
- States: IDLE, FIND_EXIT, FIND_ENTRY, WALK, DONE, FAIL.
- start accept:
  - Clears path, steps, done and fail; x = 0; sx = 0; latches left_hand.
  - Goes to FIND_EXIT.
  - start while busy is ignored.
- FIND_EXIT (one column per cycle):
  - If maze[SIZE-1][sx] = 0: go to FIND_ENTRY.
  - Else if sx = SIZE-1: go to FAIL.
  - Else sx++.
- FIND_ENTRY (one column per cycle on row 0, same rule using x):
  - On finding an open cell: path[0][x] = 1, heading = SOUTH, go to WALK.
  - If no open cell by column SIZE-1: go to FAIL.
- WALK (one cycle per evaluation):
  - If (x,y) = (sx,sy): go to DONE, no move.
  - Else if steps = MAX_STEPS: go to FAIL.
  - Else take the first open neighbour in preference order:
    - Right-hand: right turn, straight, left turn, back.
    - Left-hand: left turn, straight, right turn, back.
  - Heading/offsets: N = y-1, E = x+1, S = y+1, W = x-1.
  - A neighbour outside 0..SIZE-1 is a wall. No wrap-around; never index out of range.
  - On a move: update x, y and heading; set path bit of the new cell; steps++ (saturates at MAX_STEPS).
  - All four neighbours are walls: go to FAIL.
- DONE: done = 1, busy = 0, hold x, y, steps and path.
- FAIL: fail = 1, busy = 0, hold x, y, steps and path.
- done and fail are never both 1.
- Latency: accept to done = (sx+1) + (entry column+1) + moves + 1 cycles.

Optional Feature:
- Macro: MAZE_WALKER_PATH_EN.
- Defined: the path register and output are implemented as above.
- Undefined: the path register is not built and path is tied to all 0. All other behaviour is identical; this saves SIZE*SIZE flops.

Decomposition:
- Package maze_pkg holds:
  - typedef enum state_t (IDLE, FIND_EXIT, FIND_ENTRY, WALK, DONE, FAIL);
  - typedef enum dir_t (NORTH, EAST, SOUTH, WEST), 2-bit;
  - functions turn_right(dir_t), turn_left(dir_t), turn_back(dir_t).
- Sub-module maze_nbr_sel, combinational:
  - Inputs: maze, x, y, heading, left_hand.
  - Outputs: next_x, next_y, next_heading, blocked.
  - Contains the bounds checking and the preference order.

Test Plan:
- Corridor, SIZE = 5, column 2 open in all rows, rest walls; start, right-hand -> entry (2,0), exit (2,4), done with steps = 4, path bit 2 set in rows 0-4 only.
- Fork maze, SIZE = 5, open cells:
  - row 0: col 2;
  - row 1: cols 1-3;
  - rows 2-3: cols 1 and 3;
  - row 4: col 3.
  - Right-hand -> done, steps = 11 via dead end (1,3). Left-hand -> done, steps = 5, path cols 1 and 2 clear in rows 2-3.
- Row 4 all walls -> fail after 5 FIND_EXIT cycles, busy = 0, steps = 0, done = 0.
- Corridor with MAX_STEPS = 3 -> fail at (2,3), steps = 3. A second start with MAX_STEPS unchanged repeats the same result, proving flags and path were cleared.
- Fork maze, rst asserted for 1 cycle at step 6 -> same cycle all outputs return to reset values, path = 0. A start during busy in a later run is ignored.
- Compile without MAZE_WALKER_PATH_EN, corridor maze -> path stays 0, steps = 4, done = 1.
